// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared SPI master state encoding
package spi_master_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } state_t;
endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: reloadable down-counter issuing one tick every div+1 enabled cycles
module spi_clkgen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);
  logic [DIV_WIDTH-1:0] cnt;
  assign tick = en && cnt == '0;
  // reload on clear or tick, otherwise count down while enabled
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (clr || tick) cnt <= div;
    else if (en) cnt <= cnt - 1'b1;
endmodule

// File: rtl/spi_master.sv
// spi_master: full-duplex MSB-first SPI master, all CPOL/CPHA modes, per-slave select
module spi_master
  import spi_master_pkg::*;
#(
  parameter int SLAVES    = 1,
  parameter int D_WIDTH   = 8,
  parameter int DIV_WIDTH = 8,
  localparam int SEL_WIDTH = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic [SEL_WIDTH-1:0] slave_sel,
  input  logic [D_WIDTH-1:0]   tx_data,
  output logic [D_WIDTH-1:0]   rx_data,
  output logic                 busy,
  output logic                 done,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
  output logic [SLAVES-1:0]    ss_n
);
  localparam int E_WIDTH = $clog2(2 * D_WIDTH);
  localparam logic [E_WIDTH-1:0] LAST = E_WIDTH'(2 * D_WIDTH - 1);
  state_t state, next;
  logic [E_WIDTH-1:0] ecnt;
  logic [D_WIDTH-1:0] sr;
  logic [DIV_WIDTH-1:0] div_q;
  logic [SEL_WIDTH-1:0] sel_q;
  logic cpha_q, done_q, tick, accept;
  // the done cycle still counts as busy so a start coinciding with done is dropped
  assign accept = start && state == IDLE && !done_q;
  assign busy = state != IDLE || done_q;
  assign done = done_q;
  spi_clkgen #(.DIV_WIDTH(DIV_WIDTH)) u_clkgen (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state != IDLE),
    .div  (accept ? clk_div : div_q),
    .tick (tick)
  );
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  // next state: every non-idle phase advances on divider ticks only
  always_comb begin
    next = state;
    if (accept) next = LEAD;
    else if (tick) next = state == LEAD ? XFER : state == XFER ? (ecnt == LAST ? TRAIL : XFER) : IDLE;
  end
  // frame datapath: config latch, sclk toggling, shift register, result capture
  always_ff @(posedge clk)
    if (rst) begin
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      rx_data <= '0;
      done_q  <= 1'b0;
      sr      <= '0;
      ecnt    <= '0;
      cpha_q  <= 1'b0;
      div_q   <= '0;
      sel_q   <= '0;
    end else begin
      done_q <= state == TRAIL && tick;
      if (state == IDLE) sclk <= cpol;
      if (accept) begin
        cpha_q <= cpha;
        div_q  <= clk_div;
        sel_q  <= slave_sel;
        sr     <= tx_data;
        ecnt   <= '0;
        if (!cpha) mosi <= tx_data[D_WIDTH-1];
      end
      if (state == XFER && tick) begin
        sclk <= !sclk;
        ecnt <= ecnt + 1'b1;
        if (ecnt[0] == cpha_q) sr <= {sr[D_WIDTH-2:0], miso};
        else if (ecnt != LAST) mosi <= sr[D_WIDTH-1];
      end
      if (state == TRAIL && tick) rx_data <= sr;
    end
  // out-of-range selects match no line, leaving every ss_n high
  for (genvar i = 0; i < SLAVES; i++) begin : g_ss
    assign ss_n[i] = !(state != IDLE && sel_q == SEL_WIDTH'(i));
  end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized SPI master bench with a behavioural slave/monitor model
module tb_spi_master;
  logic clk = 0, rst = 1, start = 0, cpol = 0, cpha = 0;
  logic [7:0] clk_div = 0, tx_data = 0;
  logic [2:0] slave_sel = 0;
  logic [7:0] rx_data;
  logic busy, done, sclk, mosi, miso;
  logic [4:0] ss_n;
  int checks = 0, errors = 0;
  logic [7:0] m_resp = 0;
  logic m_cpha = 0, s_bit = 0, psclk = 0, pmosi = 0;
  bit m_loop = 0;
  int k = 0, rises = 0, mon_bad = 0, since = 0, imin = 0, imax = 0, b = 0;
  logic [7:0] rec = 0;

  spi_master #(.SLAVES(5), .D_WIDTH(8), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
    .slave_sel(slave_sel), .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  always #5 clk = ~clk;
  assign miso = m_loop ? mosi : s_bit;

  // SPI-level observer and slave: counts sclk edges, records mosi at sample edges,
  // measures half-periods and shifts out m_resp MSB first per the CPHA rules
  initial forever begin
    @(negedge clk);
    if (!busy || rst) begin
      k = 0; rises = 0; mon_bad = 0; since = 0; imin = 1000; imax = 0; rec = 0;
    end else begin
      since++;
      if (sclk !== psclk) begin
        if (k > 0) begin
          if (since < imin) imin = since;
          if (since > imax) imax = since;
        end
        since = 0;
        if (sclk) rises++;
        if (k[0] == m_cpha) begin
          if (mosi !== pmosi) mon_bad++;
          rec = {rec[6:0], mosi};
        end
        k++;
      end
    end
    psclk = sclk;
    pmosi = mosi;
    b = m_cpha ? (k > 0 ? (k - 1) / 2 : 0) : k / 2;
    if (b > 7) b = 7;
    s_bit = m_resp[7-b];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic run_frame(input logic [7:0] t, r, input logic pol, pha, input logic [7:0] dv,
                           input logic [2:0] s, input bit lp, output int lat, output bit ss_ok);
    logic [4:0] exp_ss;
    exp_ss = s < 5 ? ~(5'd1 << s) : 5'h1f;
    m_resp = r; m_cpha = pha; m_loop = lp;
    tx_data = t; cpol = pol; cpha = pha; clk_div = dv; slave_sel = s;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0; lat = 1; ss_ok = 1;
    while (!done && lat < 3000) begin
      if (ss_n !== exp_ss) ss_ok = 0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, sclk, mosi} !== 4'b0) begin errors++; $display("FAIL reset_ctl got %b want 0000", {busy, done, sclk, mosi}); end
    checks++;
    if (rx_data !== 8'h00 || ss_n !== 5'h1f) begin errors++; $display("FAIL reset_data got rx=%h ss=%b want 00/11111", rx_data, ss_n); end
    rst = 0;
    cpol = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (sclk !== 1'b1) begin errors++; $display("FAIL idle_cpol got %b want 1", sclk); end
    cpol = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0;
    int lat; bit ok;
    run_frame(8'hA5, 8'h00, 0, 0, 8'd0, 3'd0, 1, lat, ok);
    checks++;
    if (rx_data !== 8'hA5) begin errors++; $display("FAIL t1_rx got %h want a5", rx_data); end
    checks++;
    if (lat != 19) begin errors++; $display("FAIL t1_latency got %0d want 19", lat); end
    checks++;
    if (rises != 8) begin errors++; $display("FAIL t1_rises got %0d want 8", rises); end
    checks++;
    if (!ok || ss_n !== 5'h1f) begin errors++; $display("FAIL t1_ss got ok=%0d ss=%b want 1/11111", ok, ss_n); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse got %b want 0", done); end
  endtask

  task automatic test_modes;
    int lat; bit ok;
    for (int m = 0; m < 4; m++) begin
      run_frame(8'h3C, 8'hC3, m[1], m[0], 8'd0, 3'd0, 0, lat, ok);
      checks++;
      if (rx_data !== 8'hC3 || rec !== 8'h3C) begin errors++; $display("FAIL t2_mode%0d got rx=%h mosi=%h want c3/3c", m, rx_data, rec); end
      checks++;
      if (mon_bad != 0 || sclk !== m[1] || lat != 19) begin errors++; $display("FAIL t2_timing%0d got unstable=%0d sclk=%b lat=%0d want 0/%b/19", m, mon_bad, sclk, lat, m[1]); end
    end
    for (int i = 0; i < 12; i++) begin
      logic [7:0] t, r, dv; logic pol, pha; logic [2:0] s; bit lp; int exp_lat;
      t = 8'($urandom); r = 8'($urandom); pol = 1'($urandom); pha = 1'($urandom);
      dv = 8'($urandom_range(0, 3)); s = 3'($urandom_range(0, 4)); lp = 1'($urandom);
      exp_lat = 1 + 18 * (int'(dv) + 1);
      run_frame(t, r, pol, pha, dv, s, lp, lat, ok);
      checks++;
      if (rx_data !== (lp ? t : r) || rec !== t) begin errors++; $display("FAIL rand%0d_data got rx=%h mosi=%h want %h/%h", i, rx_data, rec, lp ? t : r, t); end
      checks++;
      if (lat != exp_lat || imin != int'(dv) + 1 || imax != int'(dv) + 1) begin errors++; $display("FAIL rand%0d_timing got lat=%0d half=%0d..%0d want %0d/%0d", i, lat, imin, imax, exp_lat, int'(dv) + 1); end
      checks++;
      if (!ok || mon_bad != 0 || sclk !== pol || rises != 8) begin errors++; $display("FAIL rand%0d_pins got ss_ok=%0d unstable=%0d sclk=%b rises=%0d want 1/0/%b/8", i, ok, mon_bad, sclk, rises, pol); end
    end
  endtask

  task automatic test_divider;
    int lat; bit ok;
    run_frame(8'h5A, 8'h96, 0, 0, 8'd3, 3'd1, 0, lat, ok);
    checks++;
    if (lat != 73) begin errors++; $display("FAIL t3_latency got %0d want 73", lat); end
    checks++;
    if (imin != 4 || imax != 4 || rx_data !== 8'h96) begin errors++; $display("FAIL t3_half got %0d..%0d rx=%h want 4..4 rx=96", imin, imax, rx_data); end
  endtask

  task automatic test_slaves;
    int lat; bit ok;
    run_frame(8'h81, 8'h7E, 1, 0, 8'd0, 3'd2, 0, lat, ok);
    checks++;
    if (!ok || rx_data !== 8'h7E) begin errors++; $display("FAIL t4_sel2 got ss_ok=%0d rx=%h want 1/7e", ok, rx_data); end
    run_frame(8'h42, 8'h24, 0, 1, 8'd0, 3'd7, 1, lat, ok);
    checks++;
    if (!ok || lat != 19 || rx_data !== 8'h42) begin errors++; $display("FAIL t4_sel7 got ss_ok=%0d lat=%0d rx=%h want 1/19/42", ok, lat, rx_data); end
  endtask

  task automatic test_busy;
    int n, dones;
    m_loop = 1; m_cpha = 0; cpol = 0; cpha = 0; clk_div = 8'd1; tx_data = 8'hC6; slave_sel = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    n = 1;
    while (!done && n < 500) begin
      if (n == 10) begin tx_data = 8'h11; clk_div = 8'd0; start = 1; end
      else start = 0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 37 || rx_data !== 8'hC6) begin errors++; $display("FAIL t5_first got lat=%0d rx=%h want 37/c6", n, rx_data); end
    tx_data = 8'h22; start = 1;
    @(negedge clk);
    start = 0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL t5_done_start got busy=%b done=%b want 0/0", busy, done); end
    tx_data = 8'h5B; clk_div = 8'd0; start = 1;
    @(negedge clk);
    start = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL t5_next_accept got busy=%b want 1", busy); end
    n = 1;
    while (!done && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (n != 19 || rx_data !== 8'h5B) begin errors++; $display("FAIL t5_second got lat=%0d rx=%h want 19/5b", n, rx_data); end
    dones = 0;
    repeat (40) begin @(negedge clk); if (done) dones++; end
    checks++;
    if (dones != 0 || busy !== 1'b0) begin errors++; $display("FAIL t5_no_queue got dones=%0d busy=%b want 0/0", dones, busy); end
  endtask

  task automatic test_reset_mid;
    int n, dones;
    m_loop = 1; m_cpha = 0; cpol = 1; cpha = 0; clk_div = 8'd0; tx_data = 8'hF0; slave_sel = 3'd3;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (k < 5 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (k < 5) begin errors++; $display("FAIL t6_reach_edge got k=%0d want 5", k); end
    rst = 1;
    @(negedge clk);
    checks++;
    if (ss_n !== 5'h1f || busy !== 1'b0 || sclk !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL t6_abort got ss=%b busy=%b sclk=%b done=%b want 11111/0/0/0", ss_n, busy, sclk, done); end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL t6_rx got %h want 00", rx_data); end
    rst = 0; cpol = 0;
    dones = 0;
    repeat (60) begin @(negedge clk); if (done) dones++; end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL t6_no_done got %0d want 0", dones); end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_modes;
    test_divider;
    test_slaves;
    test_busy;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
